// File: rtl/pulse_gen_pkg.sv
// Shared constants and state encoding for the pulse-train generator.
package pulse_gen_pkg;

  localparam int DEF_CNT_W      = 32;
  localparam int CFG_PERIOD_MIN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } pulse_state_e;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between the sequencing logic (master) and the generator (slave).
interface pulse_train_gen_if import pulse_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_count;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             lock_lost;

  modport master (
    output start, stop, cfg_delay, cfg_period, cfg_width, cfg_count,
    input  pulse_out, busy, done, cfg_err, lock_lost
  );

  modport slave (
    input  start, stop, cfg_delay, cfg_period, cfg_width, cfg_count,
    output pulse_out, busy, done, cfg_err, lock_lost
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  // shift the async level through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: delay, then count periods of width-high pulses.
module pulse_train_gen import pulse_gen_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  pulse_train_gen_if.slave bus
);

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_DELAY = DELAY;
  localparam logic [1:0]       ST_RUN   = RUN;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(CFG_PERIOD_MIN);

  logic             lock_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d, width_q, width_d, count_q, count_d;
  logic [CNT_W-1:0] dly_q, dly_d, phase_q, phase_d, idx_q, idx_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
  logic             cfg_err_q, cfg_err_d, lock_lost_q, lock_lost_d;
  logic             req, accept, abort, period_end, last_pulse, enter_run;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (pll_locked),
    .q_out (lock_s)
  );

  // decode handshake events; stop masks start in IDLE and aborts elsewhere
  always_comb begin
    req        = (state_q == ST_IDLE) && bus.start && !bus.stop;
    accept     = req && lock_s && (bus.cfg_period >= PER_MIN);
    abort      = (state_q != ST_IDLE) && (bus.stop || !lock_s);
    period_end = (state_q == ST_RUN) && (phase_q == period_q - ONE);
    last_pulse = period_end && (count_q != '0) && (idx_q + ONE == count_q);
  end

  // sequencing FSM and status strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (bus.cfg_delay == '0) ? ST_RUN : ST_DELAY;
      ST_DELAY: if (abort) state_d = ST_IDLE;
                else if (dly_q == '0) state_d = ST_RUN;
      ST_RUN:   if (abort || last_pulse) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    enter_run   = (state_d == ST_RUN) && (state_q != ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = last_pulse && !abort;
    cfg_err_d   = req && (bus.cfg_period < PER_MIN);
    lock_lost_d = lock_lost_q;
    if (accept)
      lock_lost_d = 1'b0;
    else if (abort && !lock_s)
      lock_lost_d = 1'b1;
  end

  // config latch, delay down-counter, phase/index counters and next pulse level
  always_comb begin
    period_d = accept ? bus.cfg_period : period_q;
    width_d  = accept ? bus.cfg_width  : width_q;
    count_d  = accept ? bus.cfg_count  : count_q;
    dly_d    = '0;
    if (accept)
      dly_d = (bus.cfg_delay == '0) ? '0 : bus.cfg_delay - ONE;
    else if ((state_q == ST_DELAY) && (state_d == ST_DELAY))
      dly_d = dly_q - ONE;
    phase_d = '0;
    idx_d   = '0;
    if ((state_d == ST_RUN) && !enter_run) begin
      phase_d = period_end ? '0 : phase_q + ONE;
      idx_d   = period_end ? idx_q + ONE : idx_q;
    end
    // phase_d is the phase of the cycle the registered output will cover
    pulse_d = (state_d == ST_RUN) && (phase_d < width_d);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      period_q    <= '0;
      width_q     <= '0;
      count_q     <= '0;
      dly_q       <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      width_q     <= width_d;
      count_q     <= count_d;
      dly_q       <= dly_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.lock_lost = lock_lost_q;

endmodule
